// File: rtl/dmem_arbiter_if.sv
// Request/response/memory bundle for the data-memory arbiter.
// slave  : the arbiter's view (takes requests, drives the memory side).
// master : the view of the requesters and memory model that surround it.
interface dmem_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic        req0_we;
   logic [3:0]  req0_be;
   logic [31:0] req0_addr;
   logic [31:0] req0_wdata;
   logic        req1_valid;
   logic        req1_ready;
   logic        req1_we;
   logic [3:0]  req1_be;
   logic [31:0] req1_addr;
   logic [31:0] req1_wdata;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic        mem_we;
   logic [3:0]  mem_byteEnable;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      output mem_we, mem_byteEnable, mem_a, mem_wd,
      input  mem_rd
   );

   modport master (
      output req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      input  mem_we, mem_byteEnable, mem_a, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, byte-enabled data memory.
// Port 0 is the core load/store path, port 1 a debug/DMA requester.
// One request is accepted per cycle; load data comes back one cycle after
// acceptance, routed to whichever port issued the load.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_arbiter_if.slave        bus,
   output logic [CNT_WIDTH-1:0] conflict_cnt
);

   logic gnt0;
   logic gnt1;
   logic both_valid;
   logic pend_valid;
   logic pend_owner;

   assign both_valid = bus.req0_valid & bus.req1_valid;

`ifdef DMEM_ARB_RR_EN
   // 1 = port 1 was granted most recently; reset value lets port 0 win first
   logic last_gnt;

   // Round-robin grant: on conflict the port not granted last wins
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (both_valid) begin
            if (last_gnt) gnt0 = 1'b1;
            else          gnt1 = 1'b1;
         end else if (bus.req0_valid) begin
            gnt0 = 1'b1;
         end else if (bus.req1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Last-grant pointer follows every accepted request
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     last_gnt <= 1'b1;
      else if (gnt0) last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
   end
`else
   // Fixed priority grant: port 0 always wins
   always_comb begin
      gnt0 = !reset & bus.req0_valid;
      gnt1 = !reset & bus.req1_valid & !bus.req0_valid;
   end
`endif

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   // Memory-side mux; with no grant the port-0 address/data pass through
   always_comb begin
      bus.mem_a          = bus.req0_addr;
      bus.mem_wd         = bus.req0_wdata;
      bus.mem_we         = 1'b0;
      bus.mem_byteEnable = 4'b0000;
      if (gnt1) begin
         bus.mem_a          = bus.req1_addr;
         bus.mem_wd         = bus.req1_wdata;
         bus.mem_we         = bus.req1_we;
         bus.mem_byteEnable = bus.req1_we ? bus.req1_be : 4'b0000;
      end else if (gnt0) begin
         bus.mem_we         = bus.req0_we;
         bus.mem_byteEnable = bus.req0_we ? bus.req0_be : 4'b0000;
      end
   end

   // Remember which port owns the read data returning next cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_owner <= 1'b0;
      end else begin
         pend_valid <= (gnt0 & ~bus.req0_we) | (gnt1 & ~bus.req1_we);
         pend_owner <= gnt1;
      end
   end

   // Steer registered memory read data to the owning port only
   always_comb begin
      bus.rsp0_valid = pend_valid & ~pend_owner;
      bus.rsp1_valid = pend_valid &  pend_owner;
      bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_rd : 32'h0;
      bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_rd : 32'h0;
   end

   // Saturating count of cycles where both ports requested
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         conflict_cnt <= '0;
      else if (both_valid && (conflict_cnt != {CNT_WIDTH{1'b1}}))
         conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small byte-enabled memory model.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_dmem_arbiter;
   logic        clk;
   logic        reset;
   logic [15:0] conflict_cnt;
   logic [3:0]  conflict_cnt_s;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem [0:255];

   dmem_arbiter_if bus ();
   dmem_arbiter_if bus_s ();

   dmem_arbiter #(.CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(conflict_cnt)
   );

   dmem_arbiter #(.CNT_WIDTH(4)) dut_s (
      .clk(clk), .reset(reset), .bus(bus_s), .conflict_cnt(conflict_cnt_s)
   );

   assign bus_s.mem_rd = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: byte-enabled write, registered read
   always @(posedge clk) begin
      if (bus.mem_we)
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteEnable[b]) mem[bus.mem_a[9:2]][b*8 +: 8] <= bus.mem_wd[b*8 +: 8];
      bus.mem_rd <= mem[bus.mem_a[9:2]];
   end

   task automatic idle();
      bus.req0_valid = 0; bus.req0_we = 0; bus.req0_be = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
      bus.req1_valid = 0; bus.req1_we = 0; bus.req1_be = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
   endtask

   task automatic drive0(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      bus.req0_valid = 1; bus.req0_we = we; bus.req0_be = be; bus.req0_addr = a; bus.req0_wdata = d;
   endtask

   task automatic drive1(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      bus.req1_valid = 1; bus.req1_we = we; bus.req1_be = be; bus.req1_addr = a; bus.req1_wdata = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      @(negedge clk);
      drive0(1'b1, 4'hF, 32'h40, 32'h12345678);
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_byteEnable !== 4'h0) begin
         errors++;
         $display("FAIL reset_mem_gate: we=%b be=%h required we=0 be=0", bus.mem_we, bus.mem_byteEnable);
      end
      @(negedge clk);
      idle();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
          bus.rsp0_rdata !== 32'h0 || bus.rsp1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rsp: v0=%b v1=%b d0=%h d1=%h required all 0",
                  bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata);
      end
      checks++;
      if (conflict_cnt !== 16'd0 || bus.mem_we !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: cnt=%0d we=%b rdy0=%b rdy1=%b required 0", conflict_cnt, bus.mem_we,
                  bus.req0_ready, bus.req1_ready);
      end
   endtask

   task automatic test_p0_store_load();
      @(negedge clk);
      drive0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 || bus.mem_we !== 1'b1 ||
          bus.mem_byteEnable !== 4'hF || bus.mem_a !== 32'h10 || bus.mem_wd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL p0_store_drive: rdy0=%b rdy1=%b we=%b be=%h a=%h wd=%h required 1 0 1 f 10 deadbeef",
                  bus.req0_ready, bus.req1_ready, bus.mem_we, bus.mem_byteEnable, bus.mem_a, bus.mem_wd);
      end
      @(negedge clk);
      drive0(1'b0, 4'hF, 32'h10, 32'h0);
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_byteEnable !== 4'h0 || bus.req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL p0_load_drive: we=%b be=%h rdy0=%b required we=0 be=0 rdy0=1",
                  bus.mem_we, bus.mem_byteEnable, bus.req0_ready);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 32'hDEADBEEF || bus.rsp1_valid !== 1'b0 ||
          bus.rsp1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL p0_load_rsp: v0=%b d0=%h v1=%b d1=%h required 1 deadbeef 0 0",
                  bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata);
      end
      @(negedge clk);
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
         errors++;
         $display("FAIL p0_rsp_pulse: v0=%b required 0", bus.rsp0_valid);
      end
   endtask

   task automatic test_p1_byte_store();
      @(negedge clk);
      drive1(1'b1, 4'hF, 32'h20, 32'h11223344);
      @(negedge clk);
      drive1(1'b1, 4'h1, 32'h20, 32'h000000AA);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0 || bus.mem_byteEnable !== 4'h1 ||
          bus.mem_a !== 32'h20 || bus.mem_wd !== 32'hAA) begin
         errors++;
         $display("FAIL p1_store_drive: rdy1=%b rdy0=%b be=%h a=%h wd=%h required 1 0 1 20 aa",
                  bus.req1_ready, bus.req0_ready, bus.mem_byteEnable, bus.mem_a, bus.mem_wd);
      end
      @(negedge clk);
      drive1(1'b0, 4'hF, 32'h20, 32'h0);
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_rdata !== 32'h112233AA || bus.rsp0_valid !== 1'b0 ||
          bus.rsp0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL p1_load_rsp: v1=%b d1=%h v0=%b d0=%h required 1 112233aa 0 0",
                  bus.rsp1_valid, bus.rsp1_rdata, bus.rsp0_valid, bus.rsp0_rdata);
      end
   endtask

   task automatic test_conflict();
      logic prev;
      logic exp;
      prev = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive0(1'b0, 4'h0, 32'h10, 32'h0);
         drive1(1'b0, 4'h0, 32'h20, 32'h0);
`ifdef DMEM_ARB_RR_EN
         exp = (i % 2 == 1);
`else
         exp = 1'b0;
`endif
         #1;
         checks++;
         if (bus.req0_ready !== ~exp || bus.req1_ready !== exp) begin
            errors++;
            $display("FAIL conflict_grant[%0d]: rdy0=%b rdy1=%b required %b %b",
                     i, bus.req0_ready, bus.req1_ready, ~exp, exp);
         end
         if (i > 0) begin
            checks++;
            if (bus.rsp0_valid !== ~prev || bus.rsp1_valid !== prev ||
                (prev ? bus.rsp1_rdata : bus.rsp0_rdata) !== (prev ? 32'h112233AA : 32'hDEADBEEF)) begin
               errors++;
               $display("FAIL conflict_rsp[%0d]: v0=%b v1=%b d0=%h d1=%h required owner %0d",
                        i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata, prev);
            end
         end
         prev = exp;
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (conflict_cnt !== 16'd6) begin
         errors++;
         $display("FAIL conflict_cnt: got %0d required 6", conflict_cnt);
      end
      checks++;
      if (bus.rsp0_valid !== ~prev || bus.rsp1_valid !== prev) begin
         errors++;
         $display("FAIL conflict_last_rsp: v0=%b v1=%b required owner %0d", bus.rsp0_valid, bus.rsp1_valid, prev);
      end
   endtask

   task automatic test_reset_pulse();
      int seen;
      seen = 0;
      @(negedge clk);
      drive0(1'b0, 4'h0, 32'h10, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle();
      #1;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) seen++;
      @(negedge clk);
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) seen++;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_pulse_rsp: rsp_valid seen %0d times required 0", seen);
      end
      checks++;
      if (conflict_cnt !== 16'd0 || bus.rsp0_rdata !== 32'h0 || bus.rsp1_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulse_state: cnt=%0d d0=%h d1=%h we=%b required 0",
                  conflict_cnt, bus.rsp0_rdata, bus.rsp1_rdata, bus.mem_we);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus_s.req0_valid = 1'b1;
         bus_s.req1_valid = 1'b1;
         @(posedge clk);
         #1;
         if (i == 13) begin
            checks++;
            if (conflict_cnt_s !== 4'd14) begin
               errors++;
               $display("FAIL sat_cnt_14: got %0d required 14", conflict_cnt_s);
            end
         end
         if (i == 14) begin
            checks++;
            if (conflict_cnt_s !== 4'd15) begin
               errors++;
               $display("FAIL sat_cnt_15: got %0d required 15", conflict_cnt_s);
            end
         end
      end
      @(negedge clk);
      bus_s.req0_valid = 1'b0;
      bus_s.req1_valid = 1'b0;
      #1;
      checks++;
      if (conflict_cnt_s !== 4'd15) begin
         errors++;
         $display("FAIL sat_cnt_hold: got %0d required 15", conflict_cnt_s);
      end
      checks++;
      if (conflict_cnt !== 16'd0) begin
         errors++;
         $display("FAIL sat_main_cnt: got %0d required 0", conflict_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus_s.req0_valid = 0; bus_s.req0_we = 0; bus_s.req0_be = 0; bus_s.req0_addr = 0; bus_s.req0_wdata = 0;
      bus_s.req1_valid = 0; bus_s.req1_we = 0; bus_s.req1_be = 0; bus_s.req1_addr = 0; bus_s.req1_wdata = 0;
      test_reset();
      test_p0_store_load();
      test_p1_byte_store();
      test_conflict();
      test_reset_pulse();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, byte-enabled data memory between the core load/store path (port 0) and a secondary requester such as a debug or DMA engine (port 1). It accepts at most one request per cycle over a valid/ready handshake. It drives the memory's write-enable, byte-enable, address and write-data inputs. It routes the memory's registered read data back to the requester that issued the read, one cycle later. A saturating counter records arbitration conflicts for performance observation.

## Interface
- CNT_WIDTH, 16, width of the conflict counter
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle (combinational)
- req0_we / req1_we  input  1  1 = store, 0 = load
- req0_be / req1_be  input  4  byte enables for stores; ignored for loads
- req0_addr / req1_addr  input  32  byte address; word index is bits [31:2]
- req0_wdata / req1_wdata  input  32  store data, lane-aligned
- rsp0_valid / rsp1_valid  output  1  load data valid pulse
- rsp0_rdata / rsp1_rdata  output  32  load data
- mem_we  output  1  to memory write enable
- mem_byteEnable  output  4  to memory byte enables
- mem_a  output  32  to memory address
- mem_wd  output  32  to memory write data
- mem_rd  input  32  from memory; registered, valid the cycle after the address is sampled
- conflict_cnt  output  CNT_WIDTH  cycles in which both ports had valid asserted

## Operation
- Grant is combinational each cycle. At most one of req0_ready or req1_ready is high. A ready is high only when the matching valid is high.
- Granted port's we/be/addr/wdata go to mem_*. mem_we = granted & req_we. mem_byteEnable = granted store ? req_be : 4'b0000.
- No grant: mem_we = 0 and mem_byteEnable = 0. mem_a and mem_wd carry port-0 inputs.
- Requesters hold valid and all fields stable until ready. Dropping valid early is a protocol violation with undefined behaviour.
- Accepted load: the owner id is registered as rsp_pending with owner 0 or 1. The next cycle, the owner's rsp_valid = 1 and its rsp_rdata = mem_rd.
- Non-owner rsp_rdata = 0. Stores produce no response.
- No response backpressure. The requester must consume rsp in the cycle it is presented.
- conflict_cnt increments on every cycle with req0_valid & req1_valid. It saturates at all-ones and does not wrap.
- Back-to-back loads from either port are allowed, one per cycle. A response for cycle N and an acceptance in cycle N+1 coexist.
- Store then load to the same word on consecutive cycles returns the stored data. The store is committed at its accept edge.
- Load and store to the same word cannot occur in the same cycle, because there is a single grant.

## Timing
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_rdata = rsp1_rdata = 0.
  - rsp_pending cleared.
  - Round-robin pointer set to favour port 0.
  - conflict_cnt = 0.
- mem_we and mem_byteEnable are 0 while reset is asserted.
- Load latency: accept at edge N; response valid during cycle N+1 and sampled at edge N+1.
- Store latency: memory updated at the accept edge.
- Reset asserted between accept and response: the pending response is discarded and no rsp_valid is emitted after reset deasserts.
- Throughput: one transaction per cycle total across both ports.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on every accepted request.
  - On conflict, the port not granted last wins.
  - A port with continuous valid is therefore granted at least every second cycle.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. The pointer register is not implemented. Port 1 may starve indefinitely.

## Test plan
- Reset then idle: all outputs at reset values, mem_we=0, conflict_cnt=0.
- Port 0 stores 0xDEADBEEF with be=4'b1111 at address 0x10, then loads 0x10 the next cycle -> rsp0_valid one cycle after the load accept, rsp0_rdata=0xDEADBEEF, rsp1_valid stays 0.
- Port 1 stores 0x000000AA with be=4'b0001 over existing 0x11223344 at address 0x20, then loads -> rsp1_rdata=0x112233AA.
- Both ports issue continuous loads for 6 cycles:
  - With DMEM_ARB_RR_EN, grants alternate 0,1,0,1,0,1.
  - Without DMEM_ARB_RR_EN, all 6 grants go to port 0.
  - conflict_cnt=6 in both builds.
- Load accepted, then reset pulsed for the following cycle -> no rsp_valid ever observed for that load; outputs at reset values.
- CNT_WIDTH=4, 20 conflict cycles -> conflict_cnt holds at 15.
